// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag allocation, result capture from two broadcast ports, dependency lookup.
// Flags/queries combinational; one registered commit per cycle; rdy_in low stalls all state, full refuses issue.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif

module reorder_buffer #(
    parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    output logic [ROB_SIZE_BIT-1:0] issue_rob_id,
    output logic                    full,
    output logic                    empty,
    input  logic                    rs_ready,
    input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
    input  logic [31:0]             rs_value,
    input  logic                    lsb_ready,
    input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
    input  logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_BIT-1:0] q1_id,
    input  logic [ROB_SIZE_BIT-1:0] q2_id,
    output logic                    q1_ready,
    output logic [31:0]             q1_value,
    output logic                    q2_ready,
    output logic [31:0]             q2_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic [ROB_SIZE_BIT-1:0] commit_rob_id
);
    localparam int ENTRIES = 1 << ROB_SIZE_BIT;

    logic [ENTRIES-1:0]      busy;
    logic [ENTRIES-1:0]      done;
    logic [4:0]              rd_q    [ENTRIES];
    logic [31:0]             value_q [ENTRIES];
    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;

    logic alloc;
    logic retire;

    // count never exceeds ENTRIES, so its MSB alone marks the full state
    assign full         = count[ROB_SIZE_BIT];
    assign empty        = (count == '0);
    assign issue_rob_id = tail;
    assign alloc        = rdy_in && issue_valid && !full;
    assign retire       = rdy_in && busy[head] && done[head];

    // Stored results win over live broadcasts; lsb outranks rs when both carry the tag.
    function automatic logic [32:0] lookup(input logic [ROB_SIZE_BIT-1:0] id);
        if (done[id] || !busy[id])
            return {1'b1, value_q[id]};
        else if (lsb_ready && lsb_rob_id == id)
            return {1'b1, lsb_value};
        else if (rs_ready && rs_rob_id == id)
            return {1'b1, rs_value};
        else
            return 33'd0;
    endfunction

    assign {q1_ready, q1_value} = lookup(q1_id);
    assign {q2_ready, q2_value} = lookup(q2_id);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy          <= '0;
            done          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            commit_valid <= 1'b0;
            if (rdy_in) begin
                if (alloc) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= 1'b0;
                    rd_q[tail] <= issue_rd;
                    tail       <= tail + ROB_SIZE_BIT'(1);
                end
                if (rs_ready && busy[rs_rob_id] && !done[rs_rob_id]) begin
                    done[rs_rob_id]    <= 1'b1;
                    value_q[rs_rob_id] <= rs_value;
                end
                // later assignment lets lsb override rs on a shared tag
                if (lsb_ready && busy[lsb_rob_id] && !done[lsb_rob_id]) begin
                    done[lsb_rob_id]    <= 1'b1;
                    value_q[lsb_rob_id] <= lsb_value;
                end
                if (retire) begin
                    commit_valid  <= 1'b1;
                    commit_rd     <= rd_q[head];
                    commit_value  <= value_q[head];
                    commit_rob_id <= head;
                    busy[head]    <= 1'b0;
                    head          <= head + ROB_SIZE_BIT'(1);
                end
                if (alloc && !retire)
                    count <= count + (ROB_SIZE_BIT + 1)'(1);
                else if (retire && !alloc)
                    count <= count - (ROB_SIZE_BIT + 1)'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && issue_valid && full) begin
            $error("reorder_buffer: allocation requested while full");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for the main flow, hand sequences for stall and async reset.
module tb_reorder_buffer;
    localparam int ID_W = 3;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [ID_W-1:0] issue_rob_id;
    logic            full;
    logic            empty;
    logic            rs_ready;
    logic [ID_W-1:0] rs_rob_id;
    logic [31:0]     rs_value;
    logic            lsb_ready;
    logic [ID_W-1:0] lsb_rob_id;
    logic [31:0]     lsb_value;
    logic [ID_W-1:0] q1_id;
    logic [ID_W-1:0] q2_id;
    logic            q1_ready;
    logic [31:0]     q1_value;
    logic            q2_ready;
    logic [31:0]     q2_value;
    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_value;
    logic [ID_W-1:0] commit_rob_id;

    int tests  = 0;
    int failed = 0;

    reorder_buffer #(.ROB_SIZE_BIT(ID_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .full(full), .empty(empty),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .q1_id(q1_id), .q2_id(q2_id),
        .q1_ready(q1_ready), .q1_value(q1_value), .q2_ready(q2_ready), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_rob_id(commit_rob_id)
    );

    always #5 clk_in = ~clk_in;

    // inputs, pre-edge combinational expectations, post-edge registered expectations
    typedef struct {
        logic [31:0] iv, ird, rsv, rsid, rsval, lv, lid, lval, q1, q2;
        logic [31:0] e_tag, e_full, e_empty, e_q1r, e_q1v, e_q2r, e_q2v;
        logic [31:0] e_cv, e_crd, e_cval, e_cid, e_cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
        q1_id = '0; q2_id = '0;
    endtask

    task automatic chk_commit(input string tag, input logic [31:0] cv, input logic [31:0] crd,
                              input logic [31:0] cval, input logic [31:0] cid, input logic [31:0] cnt);
        chk({tag, " commit_valid"}, 32'(commit_valid), cv);
        chk({tag, " commit_rd"}, 32'(commit_rd), crd);
        chk({tag, " commit_value"}, commit_value, cval);
        chk({tag, " commit_rob_id"}, 32'(commit_rob_id), cid);
        chk({tag, " count"}, 32'(dut.count), cnt);
    endtask

    initial begin
        //          iv ird rsv rsid rsval  lv lid lval  q1 q2 | tag full empty q1r q1v  q2r q2v | cv crd cval cid cnt
        vecs[0]  = '{1, 1,  0, 0, 0,      0, 0, 0,      0, 1,   0, 0, 1,  1, 0,      1, 0,      0, 0, 0,      0, 1};
        vecs[1]  = '{1, 2,  0, 0, 0,      0, 0, 0,      0, 1,   1, 0, 0,  0, 0,      1, 0,      0, 0, 0,      0, 2};
        vecs[2]  = '{1, 3,  0, 0, 0,      0, 0, 0,      0, 1,   2, 0, 0,  0, 0,      0, 0,      0, 0, 0,      0, 3};
        vecs[3]  = '{0, 0,  0, 0, 0,      0, 0, 0,      2, 0,   3, 0, 0,  0, 0,      0, 0,      0, 0, 0,      0, 3};
        vecs[4]  = '{0, 0,  1, 2, 'h22,   0, 0, 0,      2, 0,   3, 0, 0,  1, 'h22,   0, 0,      0, 0, 0,      0, 3};
        vecs[5]  = '{0, 0,  1, 0, 0,      0, 0, 0,      2, 0,   3, 0, 0,  1, 'h22,   1, 0,      0, 0, 0,      0, 3};
        vecs[6]  = '{0, 0,  1, 1, 'h11,   0, 0, 0,      1, 0,   3, 0, 0,  1, 'h11,   1, 0,      1, 1, 0,      0, 2};
        vecs[7]  = '{0, 0,  0, 0, 0,      0, 0, 0,      1, 2,   3, 0, 0,  1, 'h11,   1, 'h22,   1, 2, 'h11,   1, 1};
        vecs[8]  = '{0, 0,  0, 0, 0,      0, 0, 0,      1, 2,   3, 0, 0,  1, 'h11,   1, 'h22,   1, 3, 'h22,   2, 0};
        vecs[9]  = '{0, 0,  0, 0, 0,      0, 0, 0,      0, 1,   3, 0, 1,  1, 0,      1, 'h11,   0, 3, 'h22,   2, 0};
        vecs[10] = '{1, 4,  0, 0, 0,      0, 0, 0,      3, 4,   3, 0, 1,  1, 0,      1, 0,      0, 3, 'h22,   2, 1};
        vecs[11] = '{1, 5,  0, 0, 0,      0, 0, 0,      3, 4,   4, 0, 0,  0, 0,      1, 0,      0, 3, 'h22,   2, 2};
        vecs[12] = '{1, 6,  0, 0, 0,      0, 0, 0,      3, 4,   5, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 3};
        vecs[13] = '{1, 7,  0, 0, 0,      0, 0, 0,      3, 4,   6, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 4};
        vecs[14] = '{1, 8,  0, 0, 0,      0, 0, 0,      3, 4,   7, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 5};
        vecs[15] = '{1, 9,  0, 0, 0,      0, 0, 0,      3, 4,   0, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 6};
        vecs[16] = '{1, 10, 0, 0, 0,      0, 0, 0,      3, 4,   1, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 7};
        vecs[17] = '{1, 11, 0, 0, 0,      0, 0, 0,      3, 4,   2, 0, 0,  0, 0,      0, 0,      0, 3, 'h22,   2, 8};
        vecs[18] = '{0, 0,  1, 4, 'hA,    1, 5, 'hB,    4, 5,   3, 1, 0,  1, 'hA,    1, 'hB,    0, 3, 'h22,   2, 8};
        vecs[19] = '{0, 0,  1, 6, 1,      1, 6, 2,      6, 4,   3, 1, 0,  1, 2,      1, 'hA,    0, 3, 'h22,   2, 8};
        vecs[20] = '{0, 0,  0, 0, 0,      0, 0, 0,      6, 5,   3, 1, 0,  1, 2,      1, 'hB,    0, 3, 'h22,   2, 8};
        vecs[21] = '{0, 0,  0, 0, 0,      1, 3, 'h55,   3, 7,   3, 1, 0,  1, 'h55,   0, 0,      0, 3, 'h22,   2, 8};
        vecs[22] = '{0, 0,  0, 0, 0,      0, 0, 0,      3, 7,   3, 1, 0,  1, 'h55,   0, 0,      1, 4, 'h55,   3, 7};
        vecs[23] = '{1, 12, 0, 0, 0,      0, 0, 0,      4, 7,   3, 0, 0,  1, 'hA,    0, 0,      1, 5, 'hA,    4, 7};
        vecs[24] = '{0, 0,  0, 0, 0,      0, 0, 0,      3, 5,   4, 0, 0,  0, 0,      1, 'hB,    1, 6, 'hB,    5, 6};
        vecs[25] = '{0, 0,  0, 0, 0,      0, 0, 0,      6, 0,   4, 0, 0,  1, 2,      0, 0,      1, 7, 2,      6, 5};
        vecs[26] = '{0, 0,  0, 0, 0,      0, 0, 0,      7, 0,   4, 0, 0,  0, 0,      0, 0,      0, 7, 2,      6, 5};

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("reset commit_valid", 32'(commit_valid), 0);
        chk("reset commit_rd", 32'(commit_rd), 0);
        chk("reset commit_value", commit_value, 0);
        chk("reset commit_rob_id", 32'(commit_rob_id), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset full", 32'(full), 0);
        chk("reset issue_rob_id", 32'(issue_rob_id), 0);
        rst_in = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            issue_valid = vecs[i].iv[0];
            issue_rd    = vecs[i].ird[4:0];
            rs_ready    = vecs[i].rsv[0];
            rs_rob_id   = vecs[i].rsid[ID_W-1:0];
            rs_value    = vecs[i].rsval;
            lsb_ready   = vecs[i].lv[0];
            lsb_rob_id  = vecs[i].lid[ID_W-1:0];
            lsb_value   = vecs[i].lval;
            q1_id       = vecs[i].q1[ID_W-1:0];
            q2_id       = vecs[i].q2[ID_W-1:0];
            #1;
            chk({t, " issue_rob_id"}, 32'(issue_rob_id), vecs[i].e_tag);
            chk({t, " full"}, 32'(full), vecs[i].e_full);
            chk({t, " empty"}, 32'(empty), vecs[i].e_empty);
            chk({t, " q1_ready"}, 32'(q1_ready), vecs[i].e_q1r);
            chk({t, " q1_value"}, q1_value, vecs[i].e_q1v);
            chk({t, " q2_ready"}, 32'(q2_ready), vecs[i].e_q2r);
            chk({t, " q2_value"}, q2_value, vecs[i].e_q2v);
            tick();
            chk_commit(t, vecs[i].e_cv, vecs[i].e_crd, vecs[i].e_cval, vecs[i].e_cid, vecs[i].e_cnt);
        end

        // head is tag 7 (rd 8), tag 0 holds rd 9; complete both, then stall with a ready head
        idle_inputs();
        rs_ready = 1'b1; rs_rob_id = 3'd7; rs_value = 32'h77;
        lsb_ready = 1'b1; lsb_rob_id = 3'd0; lsb_value = 32'h80;
        tick();
        chk_commit("wb7", 0, 7, 2, 6, 5);
        idle_inputs();
        tick();
        chk_commit("c7", 1, 8, 'h77, 7, 4);

        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd20;
        rs_ready = 1'b1; rs_rob_id = 3'd1; rs_value = 32'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_commit($sformatf("stall%0d", k), 0, 8, 'h77, 7, 4);
            chk($sformatf("stall%0d issue_rob_id", k), 32'(issue_rob_id), 4);
        end

        rdy_in = 1'b1;
        idle_inputs();
        q1_id = 3'd1;
        #1;
        chk("stall wb suppressed q1_ready", 32'(q1_ready), 0);
        tick();
        chk_commit("c0 wrap", 1, 9, 'h80, 0, 3);

        #2;
        rst_in = 1'b1;
        #1;
        chk("async commit_valid", 32'(commit_valid), 0);
        chk("async commit_rd", 32'(commit_rd), 0);
        chk("async commit_value", commit_value, 0);
        chk("async commit_rob_id", 32'(commit_rob_id), 0);
        chk("async empty", 32'(empty), 1);
        chk("async full", 32'(full), 0);
        chk("async issue_rob_id", 32'(issue_rob_id), 0);
        chk("async count", 32'(dut.count), 0);
        #1;
        rst_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        chk("post-reset issue_rob_id", 32'(issue_rob_id), 0);
        tick();
        idle_inputs();
        chk_commit("post-reset alloc", 0, 0, 0, 0, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
